// File: rtl/cla_word_add_sequencer.sv
// cla_word_add_sequencer
// Steps a W-bit addition through an external 8-bit carry-lookahead adder,
// one byte per cycle starting at the least significant byte. The carry
// between bytes is kept in a register. Operands arrive on a valid/ready
// handshake, and the sum and carry-out leave on a second one.
module cla_word_add_sequencer #(
  parameter int unsigned N_BYTES = 4,
  parameter int unsigned W       = 8 * N_BYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         busy,
  output logic [7:0]   adder_a,
  output logic [7:0]   adder_b,
  output logic         adder_cin,
  input  logic [7:0]   adder_s
);

  localparam int unsigned IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_carry;
  logic          r_cout;
  logic [IW-1:0] r_idx;
  logic [7:0]    w_a_byte;
  logic [7:0]    w_b_byte;
  logic          w_carry;
  logic          w_last;
  logic          w_accept;

  // Recover the carry out of bit 7 from the sign bits of the adder's
  // operands and its sum, so the shared adder needs no carry-out port.
  assign w_a_byte = r_a[8*r_idx +: 8];
  assign w_b_byte = r_b[8*r_idx +: 8];
  assign w_carry  = (w_a_byte[7] & w_b_byte[7]) |
                    ((w_a_byte[7] ^ w_b_byte[7]) & ~adder_s[7]);
  assign w_last   = (r_idx == LAST);
  assign w_accept = in_valid && (r_state == S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs and adder drive; the adder inputs are zero outside RUN
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    if (r_state == S_RUN) begin
      adder_a   = w_a_byte;
      adder_b   = w_b_byte;
      adder_cin = r_carry;
    end
  end

  // Operand capture, byte-wise sum build-up and carry ripple
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum[8*r_idx +: 8] <= adder_s;
          r_carry             <= w_carry;
          if (w_last) begin
            r_cout <= w_carry;
            r_idx  <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = r_sum;
  assign out_cout = r_cout;

endmodule

// File: tb/tb_cla_word_add_sequencer.sv
// Bench for cla_word_add_sequencer with N_BYTES=4. An 8-bit behavioural
// adder is connected to the adder_* ports.
module tb_cla_word_add_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        busy;
  logic [7:0]  adder_a;
  logic [7:0]  adder_b;
  logic        adder_cin;
  logic [7:0]  adder_s;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] cins;
  int rdy_viol;

  cla_word_add_sequencer #(.N_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_s(adder_s)
  );

  assign adder_s = adder_a + adder_b + {7'd0, adder_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // One full transaction; operands are scrambled right after the accept edge
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input int stall, output logic [31:0] s, output logic co,
                        output int lat);
    int cnt;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (!in_ready) timeout("accept");
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
    cnt = 0; rdy_viol = 0; cins = '0;
    while (!out_valid && cnt < 50) begin
      if (cnt < 4) cins[cnt] = adder_cin;
      if (in_ready) rdy_viol++;
      @(posedge clk); #1; cnt++;
    end
    lat = cnt;
    if (!out_valid) timeout("out_valid");
    s = out_sum; co = out_cout;
    repeat (stall) begin
      if (in_ready) rdy_viol++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] s;
    logic        co;
    int          lat;
    int          cnt;
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] exp33;

    vecs[0] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    vecs[2] = '{32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[5] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_cout", 64'(out_cout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_adder", 64'({adder_a, adder_b, adder_cin}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, s, co, lat);
      chk($sformatf("vec%0d_sum", i), 64'(s), 64'(vecs[i].s));
      chk($sformatf("vec%0d_cout", i), 64'(co), 64'(vecs[i].co));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      chk($sformatf("vec%0d_in_ready_busy", i), 64'(rdy_viol), 64'd0);
      if (i == 1) chk("ripple_adder_cin", 64'(cins), 64'b1110);
      chk($sformatf("vec%0d_adder_idle", i), 64'({adder_a, adder_b, adder_cin}), 64'd0);
    end

    // Backpressure: result held, new request ignored until handshake
    in_a = 32'hA5A5A5A5; in_b = 32'h0F0F0F0F; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (!out_valid) timeout("bp_out_valid");
    in_a = 32'h80000001; in_b = 32'h80000001; in_cin = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_hold", k), 64'({out_valid, in_ready, out_cout, out_sum}),
          64'({1'b1, 1'b0, 1'b0, 32'hB4B4B4B4}));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_in_ready_after", 64'({in_ready, out_valid}), 64'b10);
    @(posedge clk); #1;
    chk("bp_new_accept", 64'(busy), 64'd1);
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (!out_valid) timeout("bp2_out_valid");
    chk("bp_new_result", 64'({out_cout, out_sum}), 64'({1'b1, 32'h00000003}));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset at RUN cycle 2 aborts the transaction
    in_a = 32'h01020304; in_b = 32'h10203040; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_run_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_outputs",
        64'({in_ready, out_valid, busy, out_cout, out_sum}), 64'({1'b1, 1'b0, 1'b0, 1'b0, 32'd0}));
    chk("mid_rst_adder", 64'({adder_a, adder_b, adder_cin}), 64'd0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("mid_rst_no_result", 64'(cnt), 64'd0);
    run_op(32'h00000001, 32'h00000001, 1'b0, 0, s, co, lat);
    chk("post_rst_sum", 64'({co, s}), 64'h2);

    // Random regression with output stalls
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      exp33 = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      run_op(ra, rb, rc, int'($urandom_range(0, 3)), s, co, lat);
      if (i < 3 || {co, s} !== exp33 || lat != 4)
        chk($sformatf("rand%0d", i), 64'({lat[7:0], co, s}), 64'({8'd4, exp33}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
